// File: rtl/vmicro16_intc_apb_pkg.sv
// vmicro16 interrupt controller shared definitions.
// Register map, CLAIM valid bit and default PSELx slot.
package vmicro16_intc_apb_pkg;

  typedef enum logic [1:0] {
    INTC_ADDR_PEND  = 2'd0,
    INTC_ADDR_MASK  = 2'd1,
    INTC_ADDR_CLAIM = 2'd2,
    INTC_ADDR_DATA  = 2'd3
  } intc_addr_e;

  localparam int INTC_CLAIM_VALID = 15;
  localparam int INTC_PSELX_INDEX = 6;

endpackage

// File: rtl/vmicro16_intc_apb_prio_enc.sv
// Lowest-index-first priority encoder.
// Combinational; valid when any request bit is set.
module vmicro16_prio_enc #(
  parameter int N       = 8,
  parameter int ID_BITS = $clog2(N)
) (
  input  logic [N-1:0]       req,
  output logic               valid,
  output logic [ID_BITS-1:0] id
);

  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = ID_BITS'(i);
      end
    end
  end

endmodule

// File: rtl/vmicro16_intc_apb.sv
// vmicro16 APB interrupt controller: edge pend, mask, claim.
// Optional per-source data latching: VMICRO16_INTC_DATA_LATCH_EN.
module vmicro16_intc_apb
  import vmicro16_intc_apb_pkg::*;
#(
  parameter int NUM_INT    = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ID_BITS    = $clog2(NUM_INT)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    S_PADDR,
  input  logic                          S_PWRITE,
  input  logic                          S_PSELx,
  input  logic                          S_PENABLE,
  input  logic [DATA_WIDTH-1:0]         S_PWDATA,
  output logic [DATA_WIDTH-1:0]         S_PRDATA,
  output logic                          S_PREADY,
  input  logic [NUM_INT-1:0]            irq_in,
  input  logic [NUM_INT*DATA_WIDTH-1:0] irq_data_in,
  output logic [NUM_INT-1:0]            ints,
  output logic [NUM_INT*DATA_WIDTH-1:0] ints_data
);

  logic [NUM_INT-1:0]    prev, pend, mask;
  logic [NUM_INT-1:0]    masked, rise, clr, claim_oh;
  logic                  acc, rd, wr, claim, cv;
  logic [ID_BITS-1:0]    cid;
  logic [DATA_WIDTH-1:0] data_q, claim_word;
  logic                  unused_ok;

  assign acc      = S_PSELx & S_PENABLE;
  assign rd       = acc & ~S_PWRITE;
  assign wr       = acc & S_PWRITE;
  assign S_PREADY = acc;

  assign masked   = pend & mask;
  assign rise     = irq_in & ~prev;
  assign claim    = rd && (S_PADDR == INTC_ADDR_CLAIM) && cv;
  assign claim_oh = NUM_INT'(1) << cid;

  vmicro16_prio_enc #(
    .N       (NUM_INT),
    .ID_BITS (ID_BITS)
  ) u_enc (
    .req   (masked),
    .valid (cv),
    .id    (cid)
  );

  always_comb begin
    clr = '0;
    if (wr && (S_PADDR == INTC_ADDR_PEND))
      clr = S_PWDATA[NUM_INT-1:0];
    if (claim)
      clr = clr | claim_oh;
  end

  always_comb begin
    claim_word = '0;
    if (cv) begin
      claim_word[INTC_CLAIM_VALID] = 1'b1;
      claim_word[ID_BITS-1:0]      = cid;
    end
  end

  always_comb begin
    S_PRDATA = '0;
    if (acc) begin
      case (S_PADDR)
        INTC_ADDR_PEND:  S_PRDATA = DATA_WIDTH'(pend);
        INTC_ADDR_MASK:  S_PRDATA = DATA_WIDTH'(mask);
        INTC_ADDR_CLAIM: S_PRDATA = claim_word;
        INTC_ADDR_DATA:  S_PRDATA = data_q;
        default:         S_PRDATA = '0;
      endcase
    end
  end

  // a rise in the same cycle as a clear keeps the source pending
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev <= '0;
      pend <= '0;
      mask <= '0;
      ints <= '0;
    end else begin
      prev <= irq_in;
      pend <= (pend & ~clr) | rise;
      if (wr && (S_PADDR == INTC_ADDR_MASK))
        mask <= S_PWDATA[NUM_INT-1:0];
      ints <= masked;
    end
  end

`ifdef VMICRO16_INTC_DATA_LATCH_EN
  logic [DATA_WIDTH-1:0] lat [NUM_INT];

  for (genvar i = 0; i < NUM_INT; i++) begin : g_lat
    always_ff @(posedge clk) begin
      if (!reset)
        lat[i] <= '0;
      else if (rise[i])
        lat[i] <= irq_data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
    assign ints_data[i*DATA_WIDTH +: DATA_WIDTH] = lat[i];
  end

  always_ff @(posedge clk) begin
    if (!reset)
      data_q <= '0;
    else if (claim)
      data_q <= lat[cid];
  end
`else
  assign ints_data = irq_data_in;
  assign data_q    = '0;
`endif

  assign unused_ok = ^S_PWDATA[DATA_WIDTH-1:NUM_INT];

endmodule
